ucode_sequencer: RTL



---
 rtl/ucode_sequencer_pkg.sv | 19 +
 rtl/irq_sync.sv | 20 ++
 rtl/ucode_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ucode_sequencer_pkg.sv
// Shared types and constants for the microcode sequencer.
package ucode_sequencer_pkg;

   localparam int UC_LAST = 0;

   localparam logic [1:0] EXC_CAUSE_IRQ   = 2'd0;
   localparam logic [1:0] EXC_CAUSE_PHASE = 2'd1;

   localparam logic [2:0] PHASE_MAX = 3'd7;

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      EXEC    = 3'd1,
      EXC     = 3'd2,
      WAITING = 3'd3,
      HALTED  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchronizer for a level-sensitive asynchronous input, cleared by reset.
module irq_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= (chain << 1) | STAGES'(d);
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: phase counter, fetch/exec/exc/wait/halt state and interrupt enable.
// Optional phase-overflow watchdog enabled by defining SEQ_PHASE_WATCHDOG_EN.
module ucode_sequencer
   import ucode_sequencer_pkg::*;
#(
   parameter int IRQ_SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stall,
   input  logic       uc_last,
   input  logic       halt,
   input  logic       wait_i,
   input  logic       ei,
   input  logic       di,
   input  logic       irq,
   output logic [2:0] phase,
   output logic       fetch,
   output logic       exc_triggered,
   output logic       ir_load,
   output logic       irq_ack,
   output logic [1:0] exc_cause,
   output logic       ie,
   output logic       halted,
   output seq_state_t seq_state
);

   seq_state_t state;
   seq_state_t nxt;
   logic       irq_s;
   logic       take_irq;
   logic       wd_hit;
   logic       load;
   logic       ack;
   logic [1:0] cause;

   irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq),
      .q     (irq_s)
   );

   assign take_irq  = irq_s & ie;
   assign seq_state = state;

`ifdef SEQ_PHASE_WATCHDOG_EN
   assign wd_hit = (phase == PHASE_MAX);
`else
   assign wd_hit = 1'b0;
`endif

   // uc_last always outranks the watchdog: a sequence ending exactly at phase 7 is legal.
   always_comb begin
      nxt   = state;
      load  = 1'b0;
      ack   = 1'b0;
      cause = EXC_CAUSE_IRQ;
      case (state)
         FETCH: begin
            if (uc_last) begin
               nxt  = EXEC;
               load = 1'b1;
            end else if (wd_hit) begin
               nxt   = EXC;
               cause = EXC_CAUSE_PHASE;
            end
         end
         EXEC: begin
            if (uc_last) begin
               if (take_irq) begin
                  nxt = EXC;
                  ack = 1'b1;
               end else if (halt)   nxt = HALTED;
               else if (wait_i)     nxt = WAITING;
               else                 nxt = FETCH;
            end else if (wd_hit) begin
               nxt   = EXC;
               cause = EXC_CAUSE_PHASE;
            end
         end
         EXC:     if (uc_last || wd_hit) nxt = FETCH;
         WAITING: begin
            if (take_irq) begin
               nxt = EXC;
               ack = 1'b1;
            end else if (irq_s) nxt = FETCH;
         end
         HALTED:  nxt = HALTED;
         default: nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= FETCH;
         phase         <= '0;
         fetch         <= 1'b1;
         exc_triggered <= 1'b0;
         ir_load       <= 1'b0;
         irq_ack       <= 1'b0;
         exc_cause     <= EXC_CAUSE_IRQ;
         ie            <= 1'b0;
         halted        <= 1'b0;
      end else if (!stall) begin
         state         <= nxt;
         fetch         <= (nxt == FETCH);
         exc_triggered <= (nxt == EXC);
         halted        <= (nxt == HALTED);
         ir_load       <= load;
         irq_ack       <= ack;
         if (nxt != state)
            phase <= '0;
         else if (state == FETCH || state == EXEC || state == EXC)
            phase <= phase + 3'd1;
         // EXC entry clearing ie wins over an ei retired at the same edge.
         if (nxt == EXC && state != EXC) begin
            ie        <= 1'b0;
            exc_cause <= cause;
         end else if (state == EXEC && uc_last) begin
            if (di)      ie <= 1'b0;
            else if (ei) ie <= 1'b1;
         end
      end else begin
         ir_load <= 1'b0;
         irq_ack <= 1'b0;
      end
   end

endmodule
